// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and default widths for the writeback collector
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ROB_W  = 3;
  localparam int RD_W   = 7;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob_idx;
    logic [RD_W-1:0]   rd;
  } wb_entry_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/wb_ch_fifo.sv
// rtl/wb_ch_fifo.sv - single-clock per-channel result FIFO with synchronous clear
module wb_ch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 42,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for storage, pointers and occupancy; push and pop together keep count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers; clear empties the FIFO without touching storage.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; stale contents are unreachable once count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback collector: per-channel skid FIFOs feeding NUM_WB grant slots
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int NUM_WB    = 2,
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = wb_pkg::DATA_W,
  parameter int ROB_W     = wb_pkg::ROB_W,
  parameter int RD_W      = wb_pkg::RD_W,
  parameter int RR_MODE   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_CH-1:0]         ch_valid,
  output logic [NUM_CH-1:0]         ch_ready,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data,
  input  logic [NUM_CH*ROB_W-1:0]   ch_rob_idx,
  input  logic [NUM_CH*RD_W-1:0]    ch_rd,
  output logic [NUM_WB-1:0]         fwd_valid,
  output logic [NUM_WB*DATA_W-1:0]  fwd_data,
  output logic [NUM_WB*ROB_W-1:0]   fwd_rob_idx,
  output logic [NUM_WB*RD_W-1:0]    fwd_rd,
  output logic [NUM_WB-1:0]         wb_valid,
  output logic [NUM_WB*DATA_W-1:0]  wb_data,
  output logic [NUM_WB*ROB_W-1:0]   wb_rob_idx,
  output logic [NUM_WB*RD_W-1:0]    wb_rd
);

  localparam int        EW   = DATA_W + ROB_W + RD_W;
  localparam int        CW   = $clog2(BUF_DEPTH + 1);
  localparam int        IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic                      clr;
  logic [NUM_CH-1:0]         ready, xfer, cand, grant, push, pop, buffered;
  logic [NUM_CH-1:0][EW-1:0] in_entry, head, cand_entry;
  logic [NUM_CH-1:0][CW-1:0] count;
  logic [NUM_WB-1:0]         fwd_valid_c;
  logic [NUM_WB-1:0][EW-1:0] fwd_entry;
  logic [IW-1:0]             rr_ptr_d, rr_ptr_q;
  logic [NUM_WB-1:0]         wb_valid_d, wb_valid_q;
  logic [NUM_WB-1:0][EW-1:0] wb_entry_d, wb_entry_q;

  assign clr = rst | flush;

  // Handshake and candidate per channel: ready looks only at registered count, head beats bypass.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_entry[i]   = {ch_data[i*DATA_W +: DATA_W], ch_rob_idx[i*ROB_W +: ROB_W],
                       ch_rd[i*RD_W +: RD_W]};
      buffered[i]   = (count[i] != '0);
      ready[i]      = !clr && (count[i] < CW'(BUF_DEPTH));
      xfer[i]       = ch_valid[i] && ready[i];
      cand[i]       = !clr && (buffered[i] || xfer[i]);
      cand_entry[i] = buffered[i] ? head[i] : in_entry[i];
    end
  end

  // Two-pass scan (start..top, then 0..start-1) fills slots in priority order.
  always_comb begin
    int n_gnt;
    int last;
    int start;
    grant       = '0;
    fwd_valid_c = '0;
    fwd_entry   = '0;
    n_gnt       = 0;
    last        = 0;
    start       = (MODE == ARB_RR) ? int'(rr_ptr_q) : 0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (((p == 0) == (j >= start)) && cand[j] && (n_gnt < NUM_WB)) begin
          grant[j] = 1'b1;
          last     = j;
          for (int s = 0; s < NUM_WB; s++) begin
            if (s == n_gnt) begin
              fwd_valid_c[s] = 1'b1;
              fwd_entry[s]   = cand_entry[j];
            end
          end
          n_gnt++;
        end
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (n_gnt != 0) begin
      rr_ptr_d = (last == NUM_CH - 1) ? '0 : IW'(last + 1);
    end
  end

  // FIFO control: granted heads pop, granted bypasses never enter, other transfers push.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i]  = grant[i] && buffered[i];
      push[i] = xfer[i] && !(grant[i] && !buffered[i]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wb_ch_fifo #(
      .DEPTH (BUF_DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk       (clk),
      .clr       (clr),
      .push      (push[g]),
      .push_data (in_entry[g]),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (count[g])
    );
  end

  // Writeback stage is a plain one-cycle copy of the forwarding slots.
  always_comb begin
    wb_valid_d = fwd_valid_c;
    wb_entry_d = fwd_entry;
  end

  // Writeback and round-robin pointer registers; reset and flush both clear them.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_valid_q <= '0;
      wb_entry_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_entry_q <= wb_entry_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Unpack slot entries onto the flat output buses.
  always_comb begin
    fwd_data    = '0;
    fwd_rob_idx = '0;
    fwd_rd      = '0;
    wb_data     = '0;
    wb_rob_idx  = '0;
    wb_rd       = '0;
    for (int s = 0; s < NUM_WB; s++) begin
      fwd_data[s*DATA_W +: DATA_W]  = fwd_entry[s][EW-1 -: DATA_W];
      fwd_rob_idx[s*ROB_W +: ROB_W] = fwd_entry[s][RD_W +: ROB_W];
      fwd_rd[s*RD_W +: RD_W]        = fwd_entry[s][RD_W-1:0];
      wb_data[s*DATA_W +: DATA_W]   = wb_entry_q[s][EW-1 -: DATA_W];
      wb_rob_idx[s*ROB_W +: ROB_W]  = wb_entry_q[s][RD_W +: ROB_W];
      wb_rd[s*RD_W +: RD_W]         = wb_entry_q[s][RD_W-1:0];
    end
  end

  assign ch_ready  = ready;
  assign fwd_valid = fwd_valid_c;
  assign wb_valid  = wb_valid_q;

endmodule
